// File: rtl/uart_hub_pkg.sv
// Shared definitions for the UART receive hub.
//   - Register offsets within a channel's 4-word window.
//   - Bit positions inside the STATUS, DATA and IRQ_EN words.
//   - Receiver FSM state encoding.
package uart_hub_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_IRQEN  = 2'd3;

   localparam int unsigned DATA_VALID  = 8;
   localparam int unsigned ST_OVERRUN  = 16;
   localparam int unsigned ST_FRAMING  = 17;
   localparam int unsigned ST_BUSY     = 18;
   localparam int unsigned IRQEN_NEMPTY = 0;
   localparam int unsigned IRQEN_ERR    = 1;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

endpackage

// File: rtl/uart_rx_chan.sv
// One UART receive channel: 2-FF synchroniser, baud tick generator, 16x oversampling
// 8N1 receiver FSM, receive FIFO, sticky error flags, divisor and IRQ enable registers.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   rxd            serial input, idle high, asynchronous
//   wr_div         write strobe for the divisor register (wdata[DIV_W-1:0])
//   wr_irqen       write strobe for the IRQ enable register (wdata[1:0])
//   wr_status      write strobe for STATUS; bits 16/17 of wdata clear overrun/framing
//   wdata          bus write data
//   pop_req        DATA read strobe; pops the FIFO when non-empty
//   head           byte at the FIFO head
//   empty, count   FIFO occupancy
//   overrun, framing sticky error flags
//   busy           receiver not idle
//   div, irq_en    register contents
//   irq_req        this channel's interrupt request
module uart_rx_chan
   import uart_hub_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 27,
   parameter int unsigned DIV_W       = 16,
   localparam int unsigned AW         = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rxd,
   input  logic             wr_div,
   input  logic             wr_irqen,
   input  logic             wr_status,
   input  logic [31:0]      wdata,
   input  logic             pop_req,
   output logic [7:0]       head,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overrun,
   output logic             framing,
   output logic             busy,
   output logic [DIV_W-1:0] div,
   output logic [1:0]       irq_en,
   output logic             irq_req
);

   logic unused_wdata;
   assign unused_wdata = ^wdata;

   // Synchroniser
   logic sync1_q, rxd_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         rxd_s   <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxd_s   <= sync1_q;
      end
   end

   // Registers
   logic [DIV_W-1:0] div_q, div_act_q;
   logic [1:0]       irq_en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q    <= DIV_W'(DEFAULT_DIV);
         irq_en_q <= 2'b00;
      end else begin
         if (wr_div)   div_q    <= wdata[DIV_W-1:0];
         if (wr_irqen) irq_en_q <= wdata[1:0];
      end
   end

   // Receiver FSM and tick generator
   rx_state_e        state_q, state_d;
   logic [DIV_W-1:0] tcnt_q, tcnt_d, div_eff;
   logic [3:0]       scnt_q, scnt_d;
   logic [2:0]       bitn_q, bitn_d;
   logic [7:0]       shift_q, shift_d;
   logic             tick, push, frame_err;

   // The active divisor follows the register only while idle, so a mid-frame write
   // cannot disturb the frame in flight.
   assign div_eff = (div_act_q == '0) ? DIV_W'(1) : div_act_q;
   assign tick    = (tcnt_q == div_eff - DIV_W'(1));

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bitn_d    = bitn_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_err = 1'b0;
      // Tick counter held cleared while idle, so START begins a fresh count.
      tcnt_d    = (state_q == StIdle) ? '0 : (tick ? '0 : tcnt_q + DIV_W'(1));

      unique case (state_q)
         StIdle: begin
            if (!rxd_s) begin
               state_d = StStart;
               scnt_d  = 4'd0;
            end
         end
         StStart: begin
            if (tick) begin
               if (scnt_q == 4'd7) begin
                  scnt_d  = 4'd0;
                  bitn_d  = 3'd0;
                  state_d = rxd_s ? StIdle : StData;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
         end
         StData: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  shift_d = {rxd_s, shift_q[7:1]};
                  bitn_d  = bitn_q + 3'd1;
                  if (bitn_q == 3'd7) state_d = StStop;
               end
            end
         end
         StStop: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  state_d   = StIdle;
                  push      = rxd_s;
                  frame_err = ~rxd_s;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         tcnt_q    <= '0;
         scnt_q    <= '0;
         bitn_q    <= '0;
         shift_q   <= '0;
         div_act_q <= DIV_W'(DEFAULT_DIV);
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         scnt_q    <= scnt_d;
         bitn_q    <= bitn_d;
         shift_q   <= shift_d;
         if (state_q == StIdle) div_act_q <= div_q;
      end
   end

   // FIFO
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, pop, push_ok, ovr_set;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop     = pop_req & ~empty;
   // A pop in the same cycle frees the slot, so a push while full is still accepted.
   assign push_ok = push & (~full | pop);
   assign ovr_set = push & full & ~pop;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Sticky flags: a set in the same cycle as a W1C wins.
   logic overrun_q, framing_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
      end else begin
         if (ovr_set)                            overrun_q <= 1'b1;
         else if (wr_status && wdata[ST_OVERRUN]) overrun_q <= 1'b0;
         if (frame_err)                          framing_q <= 1'b1;
         else if (wr_status && wdata[ST_FRAMING]) framing_q <= 1'b0;
      end
   end

   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign overrun = overrun_q;
   assign framing = framing_q;
   assign busy    = (state_q != StIdle);
   assign div     = div_q;
   assign irq_en  = irq_en_q;
   assign irq_req = (irq_en_q[IRQEN_NEMPTY] & ~empty) |
                    (irq_en_q[IRQEN_ERR] & (overrun_q | framing_q));

endmodule

// File: rtl/uart_rx_hub.sv
// N-channel UART receive hub behind one Avalon-MM slave.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   rxd             per-channel serial inputs (idle high)
//   avs_address     {channel, reg}; reg 0=DATA 1=STATUS 2=DIVISOR 3=IRQ_EN
//   avs_read/write  bus strobes, avs_writedata write data
//   avs_readdata    registered read data, valid the cycle after avs_read
//   irq             registered OR of all channel interrupt requests
module uart_rx_hub
   import uart_hub_pkg::*;
#(
   parameter int unsigned NCHAN       = 2,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 27,
   parameter int unsigned DIV_W       = 16,
   localparam int unsigned AW         = $clog2(NCHAN) + 2,
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NCHAN-1:0] rxd,
   input  logic [AW-1:0]    avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq
);

   logic [31:0] chan_idx;
   logic [1:0]  reg_sel;
   logic        chan_ok;

   if (NCHAN > 1) begin : g_chan_idx
      assign chan_idx = {{(32 - (AW - 2)){1'b0}}, avs_address[AW-1:2]};
   end else begin : g_chan_zero
      assign chan_idx = '0;
   end

   assign reg_sel = avs_address[1:0];
   assign chan_ok = (chan_idx < 32'(NCHAN));

   logic [NCHAN-1:0][7:0]       head;
   logic [NCHAN-1:0][CNT_W-1:0] count;
   logic [NCHAN-1:0][DIV_W-1:0] div;
   logic [NCHAN-1:0][1:0]       irq_en;
   logic [NCHAN-1:0]            empty, overrun, framing, busy, irq_req;

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      logic sel;
      assign sel = chan_ok && (chan_idx == 32'(i));

      uart_rx_chan #(
         .FIFO_DEPTH  (FIFO_DEPTH),
         .DEFAULT_DIV (DEFAULT_DIV),
         .DIV_W       (DIV_W)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .rxd       (rxd[i]),
         .wr_div    (avs_write && sel && (reg_sel == REG_DIV)),
         .wr_irqen  (avs_write && sel && (reg_sel == REG_IRQEN)),
         .wr_status (avs_write && sel && (reg_sel == REG_STATUS)),
         .wdata     (avs_writedata),
         .pop_req   (avs_read && sel && (reg_sel == REG_DATA)),
         .head      (head[i]),
         .empty     (empty[i]),
         .count     (count[i]),
         .overrun   (overrun[i]),
         .framing   (framing[i]),
         .busy      (busy[i]),
         .div       (div[i]),
         .irq_en    (irq_en[i]),
         .irq_req   (irq_req[i])
      );
   end

   logic [31:0] rd_d, readdata_q;
   logic        irq_q;

   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (chan_ok && (chan_idx == 32'(i))) begin
            unique case (reg_sel)
               REG_DATA: begin
                  if (!empty[i]) begin
                     rd_d[7:0]        = head[i];
                     rd_d[DATA_VALID] = 1'b1;
                  end
               end
               REG_STATUS: begin
                  rd_d[CNT_W-1:0]  = count[i];
                  rd_d[ST_OVERRUN] = overrun[i];
                  rd_d[ST_FRAMING] = framing[i];
                  rd_d[ST_BUSY]    = busy[i];
               end
               REG_DIV:   rd_d[DIV_W-1:0] = div[i];
               REG_IRQEN: rd_d[1:0]       = irq_en[i];
               default:   rd_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         if (avs_read) readdata_q <= rd_d;
         irq_q <= |irq_req;
      end
   end

   assign avs_readdata = readdata_q;
   assign irq          = irq_q;

endmodule
